cprv_writeback: RTL and testbench
=================================

Name: cprv_writeback

Overview:
- Writer side of the integer register file.
- Accepts results from three producers: ALU, load/store unit (LSU) and mul/div unit (MDU). Each producer uses a valid/ready handshake.
- Arbitrates between producers, sign/zero-extends load data, and drives the register-file write port through one registered stage.
- The registered write port doubles as the forwarding source for the operand-read stage.

Parameters:
- DATA_WIDTH, 64, register data width (fixed RV64; 64 only)
- REGADDR_WIDTH, 5, register address width
- STARVE_LIMIT, 8, cycles MDU may wait before it gains top priority (1..255)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- alu_valid  in  1  ALU result valid
- alu_ready  out  1  ALU result accepted this cycle
- alu_rd  in  REGADDR_WIDTH  ALU destination register
- alu_data  in  DATA_WIDTH  ALU result
- lsu_valid  in  1  load data valid
- lsu_ready  out  1  load accepted
- lsu_rd  in  REGADDR_WIDTH  load destination
- lsu_funct3  in  3  load type (LB/LH/LW/LD/LBU/LHU/LWU)
- lsu_offset  in  3  byte offset of access within the doubleword
- lsu_rdata  in  DATA_WIDTH  raw aligned doubleword from memory
- mdu_valid  in  1  MDU result valid
- mdu_ready  out  1  MDU result accepted
- mdu_rd  in  REGADDR_WIDTH  MDU destination
- mdu_data  in  DATA_WIDTH  MDU result
- wb_en  out  1  register-file write enable (registered)
- wb_addr  out  REGADDR_WIDTH  register-file write address (registered)
- wb_data  out  DATA_WIDTH  register-file write data (registered)
- wb_src  out  2  source of current write: 0 none, 1 ALU, 2 LSU, 3 MDU (registered)

Behaviour:
- Clock and reset: one clock, clk. Synchronous active-high reset, rst.
- Reset values: wb_en=0, wb_addr=0, wb_data=0, wb_src=0, starvation counter=0. Ready outputs are combinational, so during rst all readies=0 and nothing is accepted.
- Handshake:
  - Transfer occurs when valid&&ready on a rising clk edge.
  - A producer holds valid and payload stable until accepted.
  - At most one ready is high per cycle, and only toward a source whose valid is high.
  - A ready may depend on the other sources' valids but never on its own payload.
- Priority, normal mode: ALU > LSU > MDU.
- Starvation mode:
  - Entered when starve_cnt == STARVE_LIMIT; priority becomes MDU > ALU > LSU.
  - starve_cnt increments (saturating) each cycle mdu_valid && !mdu_ready.
  - starve_cnt clears on MDU accept or whenever mdu_valid=0.
- Latency: the result accepted at edge N appears on wb_en/wb_addr/wb_data/wb_src during cycle N+1. The register file writes it at edge N+1.
- Idle cycles: when no transfer occurs, wb_en=0 next cycle; wb_addr and wb_data hold their previous values.
- x0 destination: the transfer is still accepted (ready high), but wb_en=0. wb_src still reports the source, for retire counting.
- Load extension: byte lane = lsu_offset*8.
  - LB (000): sign-extend the byte at the byte lane.
  - LH (001): sign-extend the half at offset[2:1]*16; offset[0] is ignored.
  - LW (010): sign-extend the word at offset[2]*32; offset[1:0] are ignored.
  - LD (011): full doubleword; offset is ignored.
  - LBU (100), LHU (101), LWU (110): as LB/LH/LW but zero-extended.
  - 111: write data 0, wb_en as normal.
- Throughput: one write per cycle with no bubbles. Back-to-back writes to the same rd are legal; order follows acceptance order.
- Reset mid-operation:
  - A pending wb_en is dropped; the register file does not write at the reset edge.
  - Producers must re-present their results after reset.

Decomposition:
- Package cprv_pkg:
  - wb_src_e enum (WB_NONE, WB_ALU, WB_LSU, WB_MDU).
  - funct3 load constants (F3_LB … F3_LWU).
  - DATA_WIDTH/REGADDR_WIDTH defaults.
- Sub-module cprv_load_ext: purely combinational funct3 + offset + rdata → extended data. Instantiated once.
- Arbiter, starvation counter and output register stay in cprv_writeback.

Test Plan:
- Single ALU: alu_valid=1, rd=5, data=0x1234 → alu_ready=1 the same cycle; next cycle wb_en=1, wb_addr=5, wb_data=0x1234, wb_src=1.
- Three-way contention: all valid for one cycle → ALU granted. Then LSU granted (ALU dropped), then MDU. The wb sequence shows sources 1, 2, 3 on consecutive cycles.
- Starvation, STARVE_LIMIT=8: ALU valid every cycle, MDU valid from cycle 0 → mdu_ready rises at cycle 8. The MDU write appears at cycle 9, and starve_cnt returns to 0.
- Load extension, rdata=0x8877_6655_4433_2281:
  - LB off=0 → 0xFFFF_FFFF_FFFF_FF81.
  - LBU off=0 → 0x81.
  - LH off=6 → 0xFFFF_FFFF_FFFF_8877.
  - LWU off=4 → 0x8877_6655.
  - LD → unchanged.
- x0 write: alu rd=0, data=0xDEAD → alu_ready=1, next cycle wb_en=0, wb_src=1.
- Reset mid-stream: ALU accepted at edge N, rst=1 at edge N+1 → wb_en=0, wb_data=0, wb_src=0 after that edge; readies stay 0 while rst=1.

Source files
------------

// File: rtl/cprv_pkg.sv
// Shared types and constants for the integer register-file writeback block.
package cprv_pkg;

  localparam int DEF_DATA_WIDTH    = 64;
  localparam int DEF_REGADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_LSU  = 2'd2,
    WB_MDU  = 2'd3
  } wb_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/cprv_load_ext.sv
// Combinational load-data extraction: selects byte/half/word lane from the
// aligned doubleword and sign- or zero-extends it according to funct3.
module cprv_load_ext
  import cprv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic [2:0]            funct3,
  input  logic [2:0]            offset,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] b_sh;
  logic [DATA_WIDTH-1:0] h_sh;
  logic [DATA_WIDTH-1:0] w_sh;

  // Halves and words ignore the low offset bits, so they shift on coarser lanes.
  assign b_sh = rdata >> {offset, 3'b000};
  assign h_sh = rdata >> {offset[2:1], 4'b0000};
  assign w_sh = rdata >> {offset[2], 5'b00000};

  always_comb begin
    data = '0;
    case (funct3)
      F3_LB:   data = {{(DATA_WIDTH-8){b_sh[7]}}, b_sh[7:0]};
      F3_LH:   data = {{(DATA_WIDTH-16){h_sh[15]}}, h_sh[15:0]};
      F3_LW:   data = {{(DATA_WIDTH-32){w_sh[31]}}, w_sh[31:0]};
      F3_LD:   data = rdata;
      F3_LBU:  data = {{(DATA_WIDTH-8){1'b0}}, b_sh[7:0]};
      F3_LHU:  data = {{(DATA_WIDTH-16){1'b0}}, h_sh[15:0]};
      F3_LWU:  data = {{(DATA_WIDTH-32){1'b0}}, w_sh[31:0]};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/cprv_writeback.sv
// Register-file writer: arbitrates ALU/LSU/MDU results, extends load data and
// drives a registered write port that also serves as the forwarding source.
module cprv_writeback
  import cprv_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int REGADDR_WIDTH = DEF_REGADDR_WIDTH,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [REGADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0]    alu_data,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [REGADDR_WIDTH-1:0] lsu_rd,
  input  logic [2:0]               lsu_funct3,
  input  logic [2:0]               lsu_offset,
  input  logic [DATA_WIDTH-1:0]    lsu_rdata,
  input  logic                     mdu_valid,
  output logic                     mdu_ready,
  input  logic [REGADDR_WIDTH-1:0] mdu_rd,
  input  logic [DATA_WIDTH-1:0]    mdu_data,
  output logic                     wb_en,
  output logic [REGADDR_WIDTH-1:0] wb_addr,
  output logic [DATA_WIDTH-1:0]    wb_data,
  output logic [1:0]               wb_src
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0]               starve_cnt;
  logic                     starved;
  logic [DATA_WIDTH-1:0]    lsu_ext;
  wb_src_e                  grant;
  logic [REGADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0]    sel_data;

  cprv_load_ext #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_ext (
    .funct3(lsu_funct3),
    .offset(lsu_offset),
    .rdata (lsu_rdata),
    .data  (lsu_ext)
  );

  assign starved = (starve_cnt == LIMIT);

  // Handshake: a result transfers on the rising edge where valid && ready.
  // Readies depend only on valids, reset and the starvation state, never on
  // payload; at most one is high and only toward a valid source.
  always_comb begin
    grant = WB_NONE;
    if (!rst) begin
      if (starved) begin
        if (mdu_valid)      grant = WB_MDU;
        else if (alu_valid) grant = WB_ALU;
        else if (lsu_valid) grant = WB_LSU;
      end else begin
        if (alu_valid)      grant = WB_ALU;
        else if (lsu_valid) grant = WB_LSU;
        else if (mdu_valid) grant = WB_MDU;
      end
    end
  end

  assign alu_ready = (grant == WB_ALU);
  assign lsu_ready = (grant == WB_LSU);
  assign mdu_ready = (grant == WB_MDU);

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    case (grant)
      WB_ALU:  begin sel_rd = alu_rd; sel_data = alu_data; end
      WB_LSU:  begin sel_rd = lsu_rd; sel_data = lsu_ext;  end
      WB_MDU:  begin sel_rd = mdu_rd; sel_data = mdu_data; end
      default: begin sel_rd = '0;     sel_data = '0;       end
    endcase
  end

  // Counts cycles the MDU is held off; saturating at the limit keeps it starved.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!mdu_valid || mdu_ready) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      wb_src  <= WB_NONE;
    end else if (grant != WB_NONE) begin
      // x0 writes are retired (source reported) but never written.
      wb_en   <= (sel_rd != '0);
      wb_addr <= sel_rd;
      wb_data <= sel_data;
      wb_src  <= grant;
    end else begin
      wb_en  <= 1'b0;
      wb_src <= WB_NONE;
    end
  end

endmodule

// File: tb/tb_cprv_writeback.sv
// Directed bench for cprv_writeback: arbitration, starvation, load extension,
// x0 handling and reset behaviour with hand-computed expectations.
module tb_cprv_writeback;

  logic        clk;
  logic        rst;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [2:0]  lsu_funct3, lsu_offset;
  logic [63:0] lsu_rdata;
  logic        mdu_valid, mdu_ready;
  logic [4:0]  mdu_rd;
  logic [63:0] mdu_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic [1:0]  wb_src;

  int n_checks = 0;
  int n_fail   = 0;

  cprv_writeback #(
    .DATA_WIDTH(64),
    .REGADDR_WIDTH(5),
    .STARVE_LIMIT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd),
    .lsu_funct3(lsu_funct3), .lsu_offset(lsu_offset), .lsu_rdata(lsu_rdata),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_src(wb_src)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle 1ns past it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; lsu_valid = 0; mdu_valid = 0;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [2:0]  off;
    logic [63:0] exp;
  } ld_vec_t;

  localparam logic [63:0] RDATA = 64'h8877_6655_4433_2281;

  ld_vec_t ld_tab[12];

  initial begin
    ld_tab[0]  = '{3'b000, 3'd0, 64'hFFFF_FFFF_FFFF_FF81};
    ld_tab[1]  = '{3'b100, 3'd0, 64'h0000_0000_0000_0081};
    ld_tab[2]  = '{3'b001, 3'd6, 64'hFFFF_FFFF_FFFF_8877};
    ld_tab[3]  = '{3'b110, 3'd4, 64'h0000_0000_8877_6655};
    ld_tab[4]  = '{3'b011, 3'd3, 64'h8877_6655_4433_2281};
    ld_tab[5]  = '{3'b001, 3'd7, 64'hFFFF_FFFF_FFFF_8877};
    ld_tab[6]  = '{3'b010, 3'd0, 64'h0000_0000_4433_2281};
    ld_tab[7]  = '{3'b101, 3'd2, 64'h0000_0000_0000_4433};
    ld_tab[8]  = '{3'b000, 3'd1, 64'h0000_0000_0000_0022};
    ld_tab[9]  = '{3'b111, 3'd0, 64'h0000_0000_0000_0000};
    ld_tab[10] = '{3'b100, 3'd7, 64'h0000_0000_0000_0088};
    ld_tab[11] = '{3'b010, 3'd5, 64'hFFFF_FFFF_8877_6655};
  end

  initial begin
    rst = 1;
    idle_inputs();
    alu_rd = 0; alu_data = 0; lsu_rd = 0; lsu_funct3 = 0; lsu_offset = 0;
    lsu_rdata = 0; mdu_rd = 0; mdu_data = 0;

    // Reset state; a valid source must see no ready while in reset.
    cycle();
    cycle();
    alu_valid = 1; alu_rd = 5'd3; alu_data = 64'h77;
    #1;
    check("rst_alu_ready", alu_ready, 0);
    check("rst_wb_en", wb_en, 0);
    check("rst_wb_addr", wb_addr, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_wb_src", wb_src, 0);
    idle_inputs();
    rst = 0;
    cycle();

    // Single ALU result.
    alu_valid = 1; alu_rd = 5'd5; alu_data = 64'h1234;
    #1;
    check("alu_ready", alu_ready, 1);
    cycle();
    idle_inputs();
    check("alu_wb_en", wb_en, 1);
    check("alu_wb_addr", wb_addr, 5);
    check("alu_wb_data", wb_data, 64'h1234);
    check("alu_wb_src", wb_src, 1);

    // Three-way contention resolved ALU, LSU, MDU on consecutive cycles.
    alu_valid = 1; alu_rd = 5'd1; alu_data = 64'h11;
    lsu_valid = 1; lsu_rd = 5'd2; lsu_funct3 = 3'b011; lsu_offset = 0; lsu_rdata = 64'h22;
    mdu_valid = 1; mdu_rd = 5'd3; mdu_data = 64'h33;
    #1;
    check("c3_alu_ready", alu_ready, 1);
    check("c3_lsu_ready", lsu_ready, 0);
    check("c3_mdu_ready", mdu_ready, 0);
    cycle();
    alu_valid = 0;
    #1;
    check("c3_wb1_src", wb_src, 1);
    check("c3_wb1_data", wb_data, 64'h11);
    check("c3_lsu_ready2", lsu_ready, 1);
    check("c3_mdu_ready2", mdu_ready, 0);
    cycle();
    lsu_valid = 0;
    #1;
    check("c3_wb2_src", wb_src, 2);
    check("c3_wb2_data", wb_data, 64'h22);
    check("c3_mdu_ready3", mdu_ready, 1);
    cycle();
    mdu_valid = 0;
    check("c3_wb3_src", wb_src, 3);
    check("c3_wb3_data", wb_data, 64'h33);
    check("c3_wb3_addr", wb_addr, 3);
    cycle();
    check("idle_wb_en", wb_en, 0);
    check("idle_wb_src", wb_src, 0);
    check("idle_wb_data_hold", wb_data, 64'h33);
    check("idle_wb_addr_hold", wb_addr, 3);

    // Starvation: ALU always valid, MDU waits until cycle 8.
    mdu_valid = 1; mdu_rd = 5'd9; mdu_data = 64'h99;
    alu_valid = 1; alu_rd = 5'd7;
    for (int c = 0; c <= 8; c++) begin
      alu_data = 64'(c + 'h100);
      #1;
      check($sformatf("starve_mdu_ready_%0d", c), mdu_ready, (c == 8));
      check($sformatf("starve_alu_ready_%0d", c), alu_ready, (c != 8));
      cycle();
      if (c < 8) check($sformatf("starve_wb_src_%0d", c), wb_src, 1);
    end
    check("starve_mdu_wb_src", wb_src, 3);
    check("starve_mdu_wb_data", wb_data, 64'h99);
    check("starve_mdu_wb_addr", wb_addr, 9);
    // Counter must have cleared: a fresh MDU request loses to the ALU again.
    mdu_data = 64'hAA;
    #1;
    check("starve_cleared", mdu_ready, 0);
    idle_inputs();
    cycle();
    cycle();

    // Load extension, back-to-back through the LSU port.
    lsu_rd = 5'd10; lsu_rdata = RDATA;
    for (int i = 0; i < 12; i++) begin
      lsu_valid = 1; lsu_funct3 = ld_tab[i].f3; lsu_offset = ld_tab[i].off;
      #1;
      check($sformatf("ld_ready_%0d", i), lsu_ready, 1);
      cycle();
      check($sformatf("ld_data_%0d", i), wb_data, ld_tab[i].exp);
      check($sformatf("ld_src_%0d", i), wb_src, 2);
      check($sformatf("ld_en_%0d", i), wb_en, 1);
    end
    idle_inputs();
    cycle();

    // x0 destination: accepted and retired, never written.
    alu_valid = 1; alu_rd = 5'd0; alu_data = 64'hDEAD;
    #1;
    check("x0_ready", alu_ready, 1);
    cycle();
    idle_inputs();
    check("x0_wb_en", wb_en, 0);
    check("x0_wb_src", wb_src, 1);

    // Reset while a write is pending.
    alu_valid = 1; alu_rd = 5'd4; alu_data = 64'h55;
    cycle();
    check("mid_wb_en_pre", wb_en, 1);
    rst = 1;
    #1;
    check("mid_rst_ready", alu_ready, 0);
    cycle();
    check("mid_wb_en", wb_en, 0);
    check("mid_wb_data", wb_data, 0);
    check("mid_wb_src", wb_src, 0);
    check("mid_rst_ready2", alu_ready, 0);
    rst = 0;
    idle_inputs();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
